// File: rtl/fir_pkg.sv
// Shared types and width helpers for the serial-MAC FIR filter.
package fir_pkg;

  // Controller states: accept a sample, run the taps, emit the result.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StOut  = 2'd2
  } fir_state_e;

  // Bits needed to index num_taps entries (at least one bit).
  function automatic int unsigned fir_addr_width(input int unsigned num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

  // Full-precision accumulator width: product width plus growth for num_taps terms.
  function automatic int unsigned fir_acc_width(input int unsigned data_w,
                                                input int unsigned coeff_w,
                                                input int unsigned num_taps);
    return data_w + coeff_w + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/fir_sample_buf.sv
// Circular sample history for the FIR filter. A write stores the sample at the write
// pointer and advances it modulo N; reads return x[n-k] from tap index k.
module fir_sample_buf
  import fir_pkg::*;
#(
  parameter int unsigned gp_data_width = 8,
  parameter int unsigned gp_num_taps   = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_an,
  input  logic                                    i_ena,
  input  logic                                    i_wr,
  input  logic [gp_data_width-1:0]                i_data,
  input  logic [fir_addr_width(gp_num_taps)-1:0]  i_tap,
  output logic [gp_data_width-1:0]                o_rd_data
);

  localparam int unsigned lp_aw = fir_addr_width(gp_num_taps);
  localparam logic [lp_aw:0]   lp_n      = (lp_aw + 1)'(gp_num_taps);
  localparam logic [lp_aw:0]   lp_nm1    = (lp_aw + 1)'(gp_num_taps - 1);
  localparam logic [lp_aw-1:0] lp_last   = lp_aw'(gp_num_taps - 1);

  logic [gp_data_width-1:0] r_buf [2**lp_aw];
  logic [lp_aw-1:0]         r_wp;
  logic [lp_aw:0]           w_rd_sum;
  logic [lp_aw-1:0]         w_rd_addr;

  // Read address (wp - 1 - k) mod N, formed as wp + (N-1) - k so it never goes negative.
  always_comb begin
    w_rd_sum  = {1'b0, r_wp} + lp_nm1 - {1'b0, i_tap};
    w_rd_addr = w_rd_sum[lp_aw-1:0];
    if (w_rd_sum >= lp_n) begin
      w_rd_addr = lp_aw'(w_rd_sum - lp_n);
    end
    o_rd_data = r_buf[w_rd_addr];
  end

  // Sample store and write pointer; frozen while i_ena is low.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      for (int unsigned i = 0; i < 2**lp_aw; i++) begin
        r_buf[i] <= '0;
      end
      r_wp <= '0;
    end else if (i_ena && i_wr) begin
      r_buf[r_wp] <= i_data;
      r_wp        <= (r_wp == lp_last) ? '0 : r_wp + 1'b1;
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// Serial-MAC FIR filter: one multiply-accumulate per cycle over N taps, then a scale,
// saturate and output stage. Optional rounding via FIR_SERIAL_MAC_ROUND_EN (default:
// truncate). Result strobe arrives N+2 enabled cycles after the accepting edge.
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter int unsigned gp_data_width  = 8,
  parameter int unsigned gp_coeff_width = 8,
  parameter int unsigned gp_num_taps    = 4
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_an,
  input  logic                                    i_ena,
  input  logic                                    i_valid,
  input  logic [gp_data_width-1:0]                i_data,
  output logic                                    o_ready,
  input  logic                                    i_coeff_wr,
  input  logic [fir_addr_width(gp_num_taps)-1:0]  i_coeff_addr,
  input  logic [gp_coeff_width-1:0]               i_coeff,
  output logic                                    o_valid,
  output logic [gp_data_width-1:0]                o_data
);

  localparam int unsigned lp_aw     = fir_addr_width(gp_num_taps);
  localparam int unsigned lp_acc_w  = fir_acc_width(gp_data_width, gp_coeff_width, gp_num_taps);
  localparam int unsigned lp_prod_w = gp_data_width + gp_coeff_width;
  // One spare bit so the rounding constant can never wrap the accumulator value.
  localparam int unsigned lp_rw     = lp_acc_w + 1;

  localparam logic [lp_aw-1:0]        lp_last_tap = lp_aw'(gp_num_taps - 1);
  localparam logic signed [lp_rw-1:0] lp_sat_max  = lp_rw'((2 ** (gp_data_width - 1)) - 1);
  localparam logic signed [lp_rw-1:0] lp_sat_min  = ~lp_sat_max;

  fir_state_e r_state;
  fir_state_e w_state_nxt;

  logic [lp_aw-1:0]                r_tap;
  logic signed [lp_acc_w-1:0]      r_acc;
  logic signed [gp_coeff_width-1:0] r_coeff [2**lp_aw];
  logic [gp_data_width-1:0]        r_res;
  logic                            r_res_vld;
  logic [gp_data_width-1:0]        r_o_data;
  logic                            r_o_valid;

  logic                            w_ready;
  logic                            w_accept;
  logic                            w_coeff_we;
  logic [gp_data_width-1:0]        w_x;
  logic signed [lp_prod_w-1:0]     w_prod;
  logic signed [lp_acc_w-1:0]      w_prod_ext;
  logic signed [lp_rw-1:0]         w_rnd;
  logic signed [lp_rw-1:0]         w_shift;
  logic [gp_data_width-1:0]        w_sat;

  assign w_ready    = (r_state == StIdle);
  assign w_accept   = i_ena && w_ready && i_valid;
  assign w_coeff_we = i_ena && w_ready && i_coeff_wr;
  assign o_ready    = w_ready;
  assign o_valid    = r_o_valid;
  assign o_data     = r_o_data;

  fir_sample_buf #(
    .gp_data_width (gp_data_width),
    .gp_num_taps   (gp_num_taps)
  ) u_sample_buf (
    .i_clk     (i_clk),
    .i_rst_an  (i_rst_an),
    .i_ena     (i_ena),
    .i_wr      (w_accept),
    .i_data    (i_data),
    .i_tap     (r_tap),
    .o_rd_data (w_x)
  );

  assign w_prod     = $signed(w_x) * r_coeff[r_tap];
  assign w_prod_ext = {{(lp_acc_w - lp_prod_w){w_prod[lp_prod_w-1]}}, w_prod};

`ifdef FIR_SERIAL_MAC_ROUND_EN
  // Half an output LSB added ahead of the shift gives round-half-up.
  localparam logic signed [lp_rw-1:0] lp_rnd = lp_rw'(2 ** (gp_coeff_width - 2));
  assign w_rnd = {r_acc[lp_acc_w-1], r_acc} + lp_rnd;
`else
  assign w_rnd = {r_acc[lp_acc_w-1], r_acc};
`endif

  assign w_shift = w_rnd >>> (gp_coeff_width - 1);

  // Clamp the scaled accumulator to the signed output range.
  always_comb begin
    w_sat = w_shift[gp_data_width-1:0];
    if (w_shift > lp_sat_max) begin
      w_sat = lp_sat_max[gp_data_width-1:0];
    end else if (w_shift < lp_sat_min) begin
      w_sat = lp_sat_min[gp_data_width-1:0];
    end
  end

  // Next-state logic: one IDLE accept, N MAC cycles, one OUT cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_valid) w_state_nxt = StMac;
      StMac:   if (r_tap == lp_last_tap) w_state_nxt = StOut;
      StOut:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register; held while i_ena is low.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_state <= StIdle;
    end else if (i_ena) begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, coefficient store and output stage; held while i_ena is low.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      r_tap     <= '0;
      r_acc     <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
      r_o_data  <= '0;
      r_o_valid <= 1'b0;
      for (int unsigned i = 0; i < 2**lp_aw; i++) begin
        r_coeff[i] <= '0;
      end
    end else if (i_ena) begin
      r_res_vld <= 1'b0;
      r_o_valid <= r_res_vld;
      if (r_res_vld) begin
        r_o_data <= r_res;
      end
      unique case (r_state)
        StIdle: begin
          if (i_valid) begin
            r_acc <= '0;
            r_tap <= '0;
          end
        end
        StMac: begin
          r_acc <= r_acc + w_prod_ext;
          r_tap <= r_tap + 1'b1;
        end
        StOut: begin
          r_res     <= w_sat;
          r_res_vld <= 1'b1;
        end
        default: ;
      endcase
      if (w_coeff_we) begin
        r_coeff[i_coeff_addr] <= i_coeff;
      end
    end
  end

endmodule

// File: doc/fir_serial_mac.md
FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- gp_data_width, 8, sample in/out width, signed two's complement.
- gp_coeff_width, 8, coefficient width, signed, Q1.(gp_coeff_width-1).
- gp_num_taps, 4, tap count N, range 2..64.
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- i_clk, in, 1, rising-edge clock.
- i_rst_an, in, 1, reset, asynchronous, active-low.
- i_ena, in, 1, synchronous active-high enable.
- i_valid, in, 1, input sample strobe.
- i_data, in, gp_data_width, input sample.
- o_ready, out, 1, block can accept a sample.
- i_coeff_wr, in, 1, coefficient write strobe.
- i_coeff_addr, in, clog2(N), coefficient index.
- i_coeff, in, gp_coeff_width, coefficient value.
- o_valid, out, 1, one-cycle result strobe.
- o_data, out, gp_data_width, filtered sample.

Function
REQ-003 i_ena low SHALL freeze all state (FSM, pointers, accumulator, outputs, coefficient writes); o_valid holds its value.
REQ-004 FSM states SHALL be IDLE, MAC, OUT; o_ready = 1 only in IDLE.
REQ-005 IDLE with i_valid=1 SHALL write i_data at the write pointer, advance the pointer modulo N, clear the accumulator and go to MAC.
REQ-006 MAC SHALL run exactly N cycles with k=0..N-1: acc += x[n-k]*c[k], where x[n-k] is read at (wp-1-k) mod N with wrap-around.
REQ-007 After the last MAC cycle the FSM SHALL enter OUT, register o_data, pulse o_valid for one cycle, and return to IDLE.
REQ-008 Latency SHALL be N+2 enabled cycles from the accepting edge to o_valid high.
REQ-009 i_valid while o_ready=0 SHALL be ignored; the sample is dropped and the state is unchanged.
REQ-010 The accumulator SHALL be gp_data_width+gp_coeff_width+clog2(N) bits, full precision, with no internal overflow.
REQ-011 o_data SHALL be acc arithmetic-shifted right by gp_coeff_width-1, then saturated to the gp_data_width signed range.
REQ-012 i_coeff_wr SHALL write c[i_coeff_addr] only when o_ready=1; it is ignored otherwise.
REQ-013 A coefficient write and i_valid in the same IDLE cycle SHALL both take effect; the new coefficient is used by that MAC run.
REQ-014 o_data SHALL hold its last value between o_valid pulses.

Reset
REQ-015 Asserting i_rst_an low SHALL immediately clear the following, including mid-MAC:
- FSM to IDLE.
- Sample buffer, coefficients, write pointer, tap counter and accumulator to 0.
- o_valid=0, o_data=0, o_ready=1.
REQ-016 A result interrupted by reset SHALL never be emitted.

Configuration
REQ-017 With FIR_SERIAL_MAC_ROUND_EN defined, REQ-011 SHALL add 2^(gp_coeff_width-2) to acc before the shift (round half up).
REQ-018 Without FIR_SERIAL_MAC_ROUND_EN, REQ-011 SHALL truncate (floor) with no adder present.

Structure
REQ-019 Package fir_pkg SHALL hold the FSM state enum and a clog2-based width constant function.
REQ-020 The circular sample buffer and write pointer SHALL be sub-module fir_sample_buf; multiply, accumulate, FSM and coefficients stay in fir_serial_mac.

Verification (N=4, widths 8/8)
REQ-021 Impulse test: c={64,32,-16,8}, inputs 127,0,0,0 -> o_data 63,31,-16,7 truncated; 64,32,-16,8 with ROUND_EN.
REQ-022 Saturation test: all c=127.
- Four inputs of 127 -> o_data 127.
- Four inputs of -128 -> o_data -128.
REQ-023 Busy-drop test: i_valid pulsed 2 cycles after acceptance -> o_ready=0, exactly one o_valid, buffer unchanged.
REQ-024 Enable-stall test: i_ena low 3 cycles mid-MAC -> o_valid arrives 9 cycles after acceptance with an unchanged result.
REQ-025 Reset mid-MAC test: -> o_valid never pulses, o_data=0, o_ready=1 immediately; next impulse yields the REQ-021 values.
